serial_link_tx: RTL and testbench
=================================

Name: serial_link_tx

Overview:
- Per-output-port serialiser that sits behind one crossbar output of the router.
- Accepts one parallel flit (`PAYLOAD_SIZE+`ADDR_SZ bits) when the routing/arbitration stage asserts `ena` while `busy` is low.
- Shifts the flit onto a narrow inter-router link, LSB beat first, with start/end-of-frame framing and receiver hold back-pressure.
- `busy` feeds back into the request/enable logic, so a new flit is only offered once the current frame has finished.

Parameters:
- LANES, 1, serial link width in bits per beat; legal range 1..W, where W = `PAYLOAD_SIZE+`ADDR_SZ.
- BEATS, derived (W+LANES-1)/LANES, data beats per frame; localparam, not overridable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- item_in  input  W  flit from crossbar output mux; address in [`ADDR_SZ-1:0].
- ena  input  1  load strobe; flit captured on an edge where ena=1 and busy=0.
- busy  output  1  high while a frame is in progress.
- tx_valid  output  1  tx_data carries a valid beat this cycle.
- tx_sof  output  1  first beat of frame.
- tx_eof  output  1  last beat of frame (data beat, or parity beat when enabled).
- tx_data  output  LANES  current beat.
- tx_hold  input  1  receiver stall; beat is held while high.

Behaviour:
- Reset (reset=0 at clk edge):
  - state=IDLE, beat counter=0, shift register=0.
  - busy=0, tx_valid=0, tx_sof=0, tx_eof=0, tx_data=0.
  - Reset overrides everything, including a frame in progress. The partial frame is abandoned with no eof, and the receiver discards it on the next sof.
- States: IDLE, SEND (plus PAR when the optional feature is compiled in).
- All outputs are registered or decoded from registered state. There is no combinational path from any input to busy or any tx_* output.
- IDLE:
  - busy=0, tx_valid=0, tx_data=0.
  - On an edge with ena=1: capture item_in into the shift register, zero-padded at the MSB end to BEATS*LANES bits. Set counter=0 and go to SEND.
  - ena while in any other state is ignored and the flit is not captured. The upstream FIFO read is gated by busy, so no data is lost.
- SEND:
  - busy=1, tx_valid=1, tx_data = shift[LANES-1:0], tx_sof = (counter==0), tx_eof = (counter==BEATS-1) without the optional feature.
  - If tx_hold=1: counter, shift register and all outputs are unchanged.
  - If tx_hold=0: shift right by LANES and increment counter. After the last beat, go to IDLE (or PAR if enabled).
- BEATS==1: tx_sof and tx_eof are both high on the single beat.
- Latency: beat 0 appears the cycle after capture. With no hold, a frame occupies BEATS cycles and busy stays high for exactly those cycles.
- Frame spacing: at least one idle cycle (busy=0) between frames; the earliest next capture is at the edge ending that idle cycle.
- tx_hold while in IDLE has no effect.
- tx_hold asserted on the last beat extends the last beat, and busy stays high.
- Counter width is clog2(BEATS+1) and it never wraps within a frame.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- When defined:
  - After the last data beat, go to PAR for one beat.
  - In PAR: tx_valid=1, tx_data[0] = even parity (XOR) over the W captured bits, other lanes 0, tx_sof=0, tx_eof=1, busy=1.
  - The last data beat has tx_eof=0. tx_hold holds PAR the same way it holds SEND. Exit PAR to IDLE.
  - Frame length is BEATS+1 cycles.
- When undefined: the PAR state, the parity register and its logic are absent, and the frame is BEATS cycles.

Test Plan (PAYLOAD_SIZE=8, ADDR_SZ=4, W=12):
1. LANES=4, ena=1 with item_in=12'hA5C in IDLE -> next 3 cycles tx_data=4'hC (sof), 4'h5, 4'hA (eof); busy=1 for those 3 cycles, then 0.
2. LANES=4, tx_hold=1 for 2 cycles during beat 1 of 12'hA5C -> 4'h5 held for 3 cycles with valid=1; eof on 4'hA; busy high for 5 cycles total.
3. LANES=5, item 12'hFFF -> BEATS=3; beats 5'h1F, 5'h1F, 5'h03 (zero-padded MSBs).
4. ena=1 every cycle, items 12'h111 then 12'h222 -> 12'h222 is ignored while busy. It is captured only if ena=1 in the idle gap cycle, and the second frame's sof appears no earlier than 2 cycles after the first frame's eof.
5. reset=0 during beat 1 -> next cycle all outputs 0 and busy=0. A fresh ena then restarts the frame from sof.
6. SERIAL_TX_PARITY_EN, LANES=4, item 12'hA5C -> 4 beats; beat 2 has eof=0; beat 3 has eof=1, tx_data=4'h0 (6 ones, even). Item 12'hA5D -> parity beat tx_data=4'h1.

Source files
------------

// File: rtl/serial_link_tx.sv
//==============================================================================
// Module      : serial_link_tx
// Description : Per-output-port link serialiser. Captures one parallel flit
//               (PAYLOAD_SIZE+ADDR_SZ bits) from the crossbar output mux and
//               shifts it onto a LANES-bit inter-router link, LSB beat first.
//               Frames are marked with sof/eof, and the receiver can stall
//               them with tx_hold.
//
// Optional    : SERIAL_TX_PARITY_EN - when defined, each frame ends with one
//               extra beat that carries the even parity of the captured flit
//               in tx_data[0].
//
// Ports       : clk      in   system clock, rising edge
//               reset    in   synchronous reset, active low
//               item_in  in   W-bit flit, address in [ADDR_SZ-1:0]
//               ena      in   load strobe, honoured only while idle
//               busy     out  frame in progress
//               tx_valid out  tx_data carries a beat
//               tx_sof   out  first beat of frame
//               tx_eof   out  last beat of frame
//               tx_data  out  LANES-bit beat
//               tx_hold  in   receiver stall, freezes the current beat
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module serial_link_tx #(
    parameter int LANES = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [`PAYLOAD_SIZE+`ADDR_SZ-1:0] item_in,
    input  logic                              ena,
    output logic                              busy,
    output logic                              tx_valid,
    output logic                              tx_sof,
    output logic                              tx_eof,
    output logic [LANES-1:0]                  tx_data,
    input  logic                              tx_hold
);

    localparam int W     = `PAYLOAD_SIZE + `ADDR_SZ;
    localparam int BEATS = (W + LANES - 1) / LANES;
    localparam int SW    = BEATS * LANES;
    localparam int CW    = $clog2(BEATS + 1);

    localparam logic [CW-1:0] c_LAST = CW'(BEATS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEND = 2'd1;
`ifdef SERIAL_TX_PARITY_EN
    localparam logic [1:0] c_ST_PAR  = 2'd2;
`endif

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_shift;
`ifdef SERIAL_TX_PARITY_EN
    logic          r_parity;
`endif

    //--------------------------------------------------------------------------
    // Frame sequencer. The shift register is zero-padded at the MSB end so
    // the final beat carries zeros in the unused upper lanes.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (ena) begin
                        r_shift  <= SW'(item_in);
                        r_cnt    <= '0;
                        r_state  <= c_ST_SEND;
`ifdef SERIAL_TX_PARITY_EN
                        r_parity <= ^item_in;
`endif
                    end
                end
                c_ST_SEND: begin
                    if (!tx_hold) begin
                        r_shift <= r_shift >> LANES;
                        if (r_cnt == c_LAST) begin
                            // Clear rather than increment so the counter never wraps.
                            r_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
                            r_state <= c_ST_PAR;
`else
                            r_state <= c_ST_IDLE;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                c_ST_PAR: begin
                    if (!tx_hold) begin
                        r_state <= c_ST_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Outputs decode only registered state, so no input reaches them
    // combinationally.
    //--------------------------------------------------------------------------
    always_comb begin
        busy     = (r_state != c_ST_IDLE);
        tx_valid = (r_state != c_ST_IDLE);
        tx_sof   = (r_state == c_ST_SEND) && (r_cnt == '0);
        tx_data  = '0;
`ifdef SERIAL_TX_PARITY_EN
        tx_eof   = (r_state == c_ST_PAR);
        if (r_state == c_ST_PAR) begin
            tx_data = LANES'(r_parity);
        end
`else
        tx_eof   = (r_state == c_ST_SEND) && (r_cnt == c_LAST);
`endif
        if (r_state == c_ST_SEND) begin
            tx_data = r_shift[LANES-1:0];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_link_tx.sv
//==============================================================================
// Module      : tb_serial_link_tx
// Description : Self-checking bench for serial_link_tx with W=12. Drives a
//               LANES=4 instance from a table of per-cycle vectors and a
//               LANES=5 instance from a hand-written sequence. Expected
//               values follow SERIAL_TX_PARITY_EN when it is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module tb_serial_link_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam bit c_PAR = 1'b1;
`else
    localparam bit c_PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [11:0] item4, item5;
    logic        ena4, ena5, hold4, hold5;
    logic        busy4, valid4, sof4, eof4;
    logic        busy5, valid5, sof5, eof5;
    logic [3:0]  data4;
    logic [4:0]  data5;

    int checks = 0;
    int errors = 0;

    serial_link_tx #(.LANES(4)) u_dut4 (
        .clk(clk), .reset(reset), .item_in(item4), .ena(ena4),
        .busy(busy4), .tx_valid(valid4), .tx_sof(sof4), .tx_eof(eof4),
        .tx_data(data4), .tx_hold(hold4)
    );

    serial_link_tx #(.LANES(5)) u_dut5 (
        .clk(clk), .reset(reset), .item_in(item5), .ena(ena5),
        .busy(busy5), .tx_valid(valid5), .tx_sof(sof5), .tx_eof(eof5),
        .tx_data(data5), .tx_hold(hold5)
    );

    // expv = {busy, valid, sof, eof, data[3:0]}
    typedef struct {
        logic        ena;
        logic [11:0] item;
        logic        hold;
        logic [7:0]  expv;
        string       name;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic e, input logic [11:0] it, input logic h,
                                input logic [7:0] ex, input string nm);
        vec_t v;
        v.ena = e; v.item = it; v.hold = h; v.expv = ex; v.name = nm;
        vq.push_back(v);
    endfunction

    // Beats after beat 1 for a LANES=4 frame: last data beat, optional parity
    // beat, optional hold on the final beat, then the idle gap.
    function automatic void add_tail(input logic [3:0] hi, input logic par,
                                     input bit hold_last, input string nm);
        if (c_PAR) begin
            add(0, 12'h0, 0, {4'b1100, hi}, {nm, "_b2"});
            add(0, 12'h0, 0, {4'b1101, 3'b000, par}, {nm, "_par"});
            if (hold_last) add(0, 12'h0, 1, {4'b1101, 3'b000, par}, {nm, "_par_hold"});
        end else begin
            add(0, 12'h0, 0, {4'b1101, hi}, {nm, "_b2"});
            if (hold_last) add(0, 12'h0, 1, {4'b1101, hi}, {nm, "_b2_hold"});
        end
        add(0, 12'h0, 0, 8'h00, {nm, "_idle"});
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] s4();
        return {busy4, valid4, sof4, eof4, data4};
    endfunction

    function automatic logic [8:0] s5();
        return {busy5, valid5, sof5, eof5, data5};
    endfunction

    initial begin
        reset = 1'b0;
        item4 = '0; item5 = '0;
        ena4 = 1'b0; ena5 = 1'b0; hold4 = 1'b0; hold5 = 1'b0;

        // Reset state, with ena pending to show reset wins.
        ena4 = 1'b1; item4 = 12'hFFF;
        step(); step();
        chk("reset4", 32'(s4()), 32'h0);
        chk("reset5", 32'(s5()), 32'h0);
        ena4 = 1'b0;
        reset = 1'b1;
        step();
        chk("post_reset_idle4", 32'(s4()), 32'h0);

        // Basic frame 12'hA5C.
        add(1, 12'hA5C, 0, {4'b1110, 4'hC}, "t1_b0");
        add(0, 12'h0,   0, {4'b1100, 4'h5}, "t1_b1");
        add_tail(4'hA, 1'b0, 1'b0, "t1");
        // Hold in idle does nothing.
        add(0, 12'h0, 1, 8'h00, "idle_hold");
        // Hold for two cycles during beat 1, and on the last beat.
        add(1, 12'hA5C, 0, {4'b1110, 4'hC}, "t2_b0");
        add(0, 12'h0,   0, {4'b1100, 4'h5}, "t2_b1");
        add(0, 12'h0,   1, {4'b1100, 4'h5}, "t2_b1_hold1");
        add(0, 12'h0,   1, {4'b1100, 4'h5}, "t2_b1_hold2");
        add_tail(4'hA, 1'b0, 1'b1, "t2");
        // 12'hA5D has odd population, parity 1.
        add(1, 12'hA5D, 0, {4'b1110, 4'hD}, "t6_b0");
        add(0, 12'h0,   0, {4'b1100, 4'h5}, "t6_b1");
        add_tail(4'hA, 1'b1, 1'b0, "t6");

        foreach (vq[i]) begin
            ena4  = vq[i].ena;
            item4 = vq[i].item;
            hold4 = vq[i].hold;
            step();
            chk(vq[i].name, 32'(s4()), 32'(vq[i].expv));
        end
        ena4 = 1'b0; hold4 = 1'b0;

        // LANES=5, 12'hFFF: three beats, top beat zero-padded.
        ena5 = 1'b1; item5 = 12'hFFF;
        step();
        chk("t3_b0", 32'(s5()), 32'({4'b1110, 5'h1F}));
        ena5 = 1'b0;
        step();
        chk("t3_b1", 32'(s5()), 32'({4'b1100, 5'h1F}));
        step();
        chk("t3_b2", 32'(s5()), 32'({3'b110, ~c_PAR, 5'h03}));
        if (c_PAR) begin
            step();
            chk("t3_par", 32'(s5()), 32'({4'b1101, 5'h00}));
        end
        step();
        chk("t3_idle", 32'(s5()), 32'h0);

        // ena held high: 12'h222 ignored while busy, taken after the idle gap.
        ena4 = 1'b1; item4 = 12'h111;
        step();
        chk("t4_b0", 32'(s4()), 32'({4'b1110, 4'h1}));
        item4 = 12'h222;
        step();
        chk("t4_b1", 32'(s4()), 32'({4'b1100, 4'h1}));
        step();
        chk("t4_b2", 32'(s4()), 32'({3'b110, ~c_PAR, 4'h1}));
        if (c_PAR) begin
            step();
            chk("t4_par", 32'(s4()), 32'({4'b1101, 4'h1}));
        end
        step();
        chk("t4_gap", 32'(s4()), 32'h0);
        step();
        chk("t4_second_sof", 32'(s4()), 32'({4'b1110, 4'h2}));
        ena4 = 1'b0;
        repeat (c_PAR ? 3 : 2) step();
        step();
        chk("t4_end_idle", 32'(s4()), 32'h0);

        // Reset mid-frame, then a clean restart.
        ena4 = 1'b1; item4 = 12'hA5C;
        step();
        ena4 = 1'b0;
        step();
        chk("t5_b1", 32'(s4()), 32'({4'b1100, 4'h5}));
        reset = 1'b0;
        step();
        chk("t5_reset4", 32'(s4()), 32'h0);
        reset = 1'b1;
        ena4 = 1'b1;
        step();
        chk("t5_restart_sof", 32'(s4()), 32'({4'b1110, 4'hC}));
        ena4 = 1'b0;
        step();
        chk("t5_restart_b1", 32'(s4()), 32'({4'b1100, 4'h5}));
        repeat (c_PAR ? 2 : 1) step();
        step();
        chk("t5_end_idle", 32'(s4()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
